// File: rtl/program_loader_pkg.sv
// Shared loader/processor definitions.
// State encoding for the program loader FSM.
package program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  localparam state_t RUN_STATE = ST_RUN;
  localparam state_t ERR_STATE = ST_ERR;

  function automatic logic is_loading(state_t s);
    return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/loader_watchdog.sv
// Idle-cycle watchdog for the program loader.
// A zero limit never expires.
module loader_watchdog #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (limit != '0)) begin
      count <= count + W'(1);
    end
  end

  // Fires on the idle cycle that would bring the count up to limit.
  assign expired = enable && !clear && (limit != '0) &&
                   (count == limit - W'(1));

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed, checksummed program into memory,
// then enables the processor.
module program_loader
  import program_loader_pkg::*;
#(
  parameter logic [7:0]  START_ADDR = 8'h00,
  parameter logic [15:0] TIMEOUT    = 16'd1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_start,
  input  logic       halt,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic [7:0] user_address,
  output logic       user_write_memory,
  output logic [7:0] in_data,
  output logic       op,
  output logic       busy,
  output logic       error
);

  state_t     state, state_n;
  logic [7:0] idx, idx_n;
  logic [7:0] len, len_n;
  logic [7:0] sum, sum_n;
  logic [7:0] addr_n, data_n;
  logic       wr_n;
  logic       accept;
  logic       expired;

  assign busy       = is_loading(state);
  assign byte_ready = busy;
  assign op         = (state == RUN_STATE);
  assign error      = (state == ERR_STATE);
  assign accept     = byte_valid && byte_ready;

  loader_watchdog #(.W(16)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept || !busy),
    .enable  (busy),
    .limit   (TIMEOUT),
    .expired (expired)
  );

  always_comb begin
    state_n = state;
    idx_n   = idx;
    len_n   = len;
    sum_n   = sum;
    wr_n    = 1'b0;
    addr_n  = user_address;
    data_n  = in_data;
    if (halt) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_ERR: begin
          if (load_start) begin
            state_n = ST_LEN;
            idx_n   = '0;
            len_n   = '0;
            sum_n   = '0;
          end
        end
        ST_LEN: begin
          if (accept) begin
            len_n   = byte_in;
            state_n = ST_DATA;
          end else if (expired) begin
            state_n = ST_ERR;
          end
        end
        ST_DATA: begin
          if (accept) begin
            wr_n   = 1'b1;
            addr_n = START_ADDR + idx;
            data_n = byte_in;
            sum_n  = sum + byte_in;
            idx_n  = idx + 8'd1;
            // len of zero wraps to FF here, giving 256 bytes
            if (idx == len - 8'd1) state_n = ST_CHK;
          end else if (expired) begin
            state_n = ST_ERR;
          end
        end
        ST_CHK: begin
          if (accept) begin
            state_n = (byte_in == sum) ? ST_RUN : ST_ERR;
          end else if (expired) begin
            state_n = ST_ERR;
          end
        end
        ST_RUN: ;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_IDLE;
      idx               <= '0;
      len               <= '0;
      sum               <= '0;
      user_write_memory <= 1'b0;
      user_address      <= '0;
      in_data           <= '0;
    end else begin
      state             <= state_n;
      idx               <= idx_n;
      len               <= len_n;
      sum               <= sum_n;
      user_write_memory <= wr_n;
      user_address      <= addr_n;
      in_data           <= data_n;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed table-driven bench for program_loader.
// u0: START_ADDR 00, TIMEOUT 10; u1: START_ADDR FE, TIMEOUT 0.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_start;
  logic       halt;
  logic [7:0] byte_in;
  logic       byte_valid;

  logic       rdy0, wr0, op0, busy0, err0;
  logic [7:0] addr0, data0;
  logic       rdy1, wr1, op1, busy1, err1;
  logic [7:0] addr1, data1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  program_loader #(.START_ADDR(8'h00), .TIMEOUT(16'd10)) u0 (
    .clk               (clk),
    .reset             (reset),
    .load_start        (load_start),
    .halt              (halt),
    .byte_in           (byte_in),
    .byte_valid        (byte_valid),
    .byte_ready        (rdy0),
    .user_address      (addr0),
    .user_write_memory (wr0),
    .in_data           (data0),
    .op                (op0),
    .busy              (busy0),
    .error             (err0)
  );

  program_loader #(.START_ADDR(8'hFE), .TIMEOUT(16'd0)) u1 (
    .clk               (clk),
    .reset             (reset),
    .load_start        (load_start),
    .halt              (halt),
    .byte_in           (byte_in),
    .byte_valid        (byte_valid),
    .byte_ready        (rdy1),
    .user_address      (addr1),
    .user_write_memory (wr1),
    .in_data           (data1),
    .op                (op1),
    .busy              (busy1),
    .error             (err1)
  );

  typedef struct {
    logic       ls, h, bv;
    logic [7:0] b;
    logic       wr;
    logic [7:0] addr, data;
    logic       op, err, busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic ls, logic h, logic bv,
                              logic [7:0] b, logic wr,
                              logic [7:0] addr, logic [7:0] data,
                              logic op, logic err, logic busy);
    vec_t v;
    v.ls = ls; v.h = h; v.bv = bv; v.b = b;
    v.wr = wr; v.addr = addr; v.data = data;
    v.op = op; v.err = err; v.busy = busy;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(logic ls, logic h, logic bv, logic [7:0] b);
    load_start = ls;
    halt       = h;
    byte_valid = bv;
    byte_in    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(string tag, logic wr, logic [7:0] addr,
                      logic [7:0] data, logic op, logic err,
                      logic busy);
    check({tag, ".wr"}, 16'(wr1), 16'(wr));
    if (wr) begin
      check({tag, ".addr"}, 16'(addr1), 16'(addr));
      check({tag, ".data"}, 16'(data1), 16'(data));
    end
    check({tag, ".op"}, 16'(op1), 16'(op));
    check({tag, ".err"}, 16'(err1), 16'(err));
    check({tag, ".busy"}, 16'(busy1), 16'(busy));
    check({tag, ".rdy"}, 16'(rdy1), 16'(busy));
  endtask

  int wr_cnt;
  logic [7:0] last_addr;

  initial begin
    // ls h bv byte | wr addr data | op err busy
    // normal load, checksum 66
    add(1,0,0,8'h00, 0,8'h00,8'h00, 0,0,1);
    add(0,0,1,8'h03, 0,8'h00,8'h00, 0,0,1);
    add(0,0,1,8'h11, 1,8'h00,8'h11, 0,0,1);
    add(0,0,1,8'h22, 1,8'h01,8'h22, 0,0,1);
    add(0,0,1,8'h33, 1,8'h02,8'h33, 0,0,1);
    add(0,0,1,8'h66, 0,8'h00,8'h00, 1,0,0);
    add(1,0,0,8'h00, 0,8'h00,8'h00, 1,0,0);
    add(0,1,0,8'h00, 0,8'h00,8'h00, 0,0,0);
    // bad checksum, then recovery
    add(1,0,0,8'h00, 0,8'h00,8'h00, 0,0,1);
    add(0,0,1,8'h02, 0,8'h00,8'h00, 0,0,1);
    add(0,0,1,8'h05, 1,8'h00,8'h05, 0,0,1);
    add(0,0,1,8'h05, 1,8'h01,8'h05, 0,0,1);
    add(0,0,1,8'h0B, 0,8'h00,8'h00, 0,1,0);
    add(0,0,0,8'h00, 0,8'h00,8'h00, 0,1,0);
    add(1,0,0,8'h00, 0,8'h00,8'h00, 0,0,1);
    add(0,1,0,8'h00, 0,8'h00,8'h00, 0,0,0);
    // timeout after 10 idle cycles
    add(1,0,0,8'h00, 0,8'h00,8'h00, 0,0,1);
    add(0,0,1,8'h02, 0,8'h00,8'h00, 0,0,1);
    add(0,0,1,8'hAA, 1,8'h00,8'hAA, 0,0,1);
    for (int i = 0; i < 9; i++)
      add(0,0,0,8'h00, 0,8'h00,8'h00, 0,0,1);
    add(0,0,0,8'h00, 0,8'h00,8'h00, 0,1,0);
    add(0,1,0,8'h00, 0,8'h00,8'h00, 0,0,0);
    // halt wins over the 2nd data byte
    add(1,0,0,8'h00, 0,8'h00,8'h00, 0,0,1);
    add(0,0,1,8'h03, 0,8'h00,8'h00, 0,0,1);
    add(0,0,1,8'h10, 1,8'h00,8'h10, 0,0,1);
    add(0,1,1,8'h20, 0,8'h00,8'h00, 0,0,0);
    add(0,0,1,8'h30, 0,8'h00,8'h00, 0,0,0);

    reset = 1'b1;
    load_start = 0; halt = 0; byte_valid = 0; byte_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.wr", 16'(wr0), 16'd0);
    check("rst.addr", 16'(addr0), 16'd0);
    check("rst.data", 16'(data0), 16'd0);
    check("rst.op", 16'(op0), 16'd0);
    check("rst.rdy", 16'(rdy0), 16'd0);
    check("rst.busy", 16'(busy0), 16'd0);
    check("rst.err", 16'(err0), 16'd0);
    reset = 1'b0;
    step(0,0,0,8'h00);

    foreach (vecs[i]) begin
      step(vecs[i].ls, vecs[i].h, vecs[i].bv, vecs[i].b);
      check($sformatf("v%0d.wr", i), 16'(wr0), 16'(vecs[i].wr));
      if (vecs[i].wr) begin
        check($sformatf("v%0d.addr", i), 16'(addr0), 16'(vecs[i].addr));
        check($sformatf("v%0d.data", i), 16'(data0), 16'(vecs[i].data));
      end
      check($sformatf("v%0d.op", i), 16'(op0), 16'(vecs[i].op));
      check($sformatf("v%0d.err", i), 16'(err0), 16'(vecs[i].err));
      check($sformatf("v%0d.busy", i), 16'(busy0), 16'(vecs[i].busy));
      check($sformatf("v%0d.rdy", i), 16'(rdy0), 16'(vecs[i].busy));
    end

    // u1: address wrap from FE
    reset = 1'b1;
    step(0,0,0,8'h00);
    reset = 1'b0;
    step(1,0,0,8'h00); chk1("w0", 0,8'h00,8'h00, 0,0,1);
    step(0,0,1,8'h03); chk1("w1", 0,8'h00,8'h00, 0,0,1);
    step(0,0,1,8'h01); chk1("w2", 1,8'hFE,8'h01, 0,0,1);
    step(0,0,1,8'h02); chk1("w3", 1,8'hFF,8'h02, 0,0,1);
    step(0,0,1,8'h03); chk1("w4", 1,8'h00,8'h03, 0,0,1);
    step(0,0,1,8'h06); chk1("w5", 0,8'h00,8'h00, 1,0,0);
    step(0,1,0,8'h00); chk1("w6", 0,8'h00,8'h00, 0,0,0);

    // u1: length 0 means 256 bytes
    step(1,0,0,8'h00);
    step(0,0,1,8'h00);
    wr_cnt = 0;
    last_addr = '0;
    for (int i = 0; i < 256; i++) begin
      step(0,0,1,8'h01);
      if (wr1) begin
        wr_cnt++;
        last_addr = addr1;
      end
    end
    check("l256.strobes", 16'(wr_cnt), 16'd256);
    check("l256.last_addr", 16'(last_addr), 16'hFD);
    chk1("l256.chk", 1,8'hFD,8'h01, 0,0,1);
    step(0,0,1,8'h00); chk1("l256.run", 0,8'h00,8'h00, 1,0,0);
    step(0,1,0,8'h00);

    // u1: TIMEOUT 0 never expires
    step(1,0,0,8'h00);
    repeat (30) step(0,0,0,8'h00);
    chk1("t0", 0,8'h00,8'h00, 0,0,1);

    // u1: reset mid-DATA
    step(0,0,1,8'h02);
    step(0,0,1,8'h07); chk1("r0", 1,8'hFE,8'h07, 0,0,1);
    reset = 1'b1;
    step(0,0,1,8'h08);
    chk1("r1", 0,8'h00,8'h00, 0,0,0);
    check("r1.addr", 16'(addr1), 16'd0);
    check("r1.data", 16'(data1), 16'd0);
    reset = 1'b0;
    step(0,0,1,8'h09); chk1("r2", 0,8'h00,8'h00, 0,0,0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter START_ADDR, default 8'h00, first memory address written.
REQ-002 SHALL have parameter TIMEOUT, default 16'd1000, max idle cycles between accepted bytes while loading; 0 disables the timeout.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port load_start  input  1  single-cycle request to begin a load.
REQ-006 SHALL have port halt  input  1  abort load or stop run; return to IDLE.
REQ-007 SHALL have port byte_in  input  8  incoming stream byte.
REQ-008 SHALL have port byte_valid  input  1  byte_in valid.
REQ-009 SHALL have port byte_ready  output  1  loader can accept byte_in.
REQ-010 SHALL have port user_address  output  8  memory address driven to the processor.
REQ-011 SHALL have port user_write_memory  output  1  one-cycle memory write strobe.
REQ-012 SHALL have port in_data  output  8  memory write data.
REQ-013 SHALL have port op  output  1  processor run enable.
REQ-014 SHALL have port busy  output  1  high in LEN, DATA, CHK.
REQ-015 SHALL have port error  output  1  high in ERR.

Function
REQ-016 SHALL implement states IDLE, LEN, DATA, CHK, RUN, ERR.
REQ-017 SHALL accept a byte only on a cycle where byte_valid and byte_ready are both 1; byte_ready SHALL be 1 exactly in LEN, DATA, CHK.
REQ-018 IDLE: on load_start (and halt=0) SHALL go to LEN, clear index, checksum and timeout counter.
REQ-019 LEN: accepted byte SHALL set length L; L=0 means 256 bytes; SHALL go to DATA.
REQ-020 DATA: byte number i (0-based) SHALL be written to address (START_ADDR + i) mod 256; address wraps 8'hFF -> 8'h00 silently.
REQ-021 Write timing: for a byte accepted at edge k, user_write_memory, user_address and in_data SHALL be registered and valid for exactly the cycle after edge k; back-to-back accepts SHALL give back-to-back strobes.
REQ-022 DATA SHALL keep a running 8-bit sum (mod 256) of data bytes; after the L-th byte SHALL go to CHK.
REQ-023 CHK: accepted byte equal to the sum SHALL go to RUN; unequal SHALL go to ERR; the checksum byte SHALL NOT be written to memory.
REQ-024 RUN: op SHALL be 1 from the cycle after entering RUN until leaving RUN; user_write_memory SHALL be 0; load_start ignored.
REQ-025 ERR: error=1, op=0; load_start SHALL restart at LEN and clear error.
REQ-026 Timeout: in LEN/DATA/CHK, counter SHALL clear on each accept and increment otherwise; reaching TIMEOUT SHALL go to ERR (TIMEOUT=0: never).
REQ-027 halt SHALL, in any state, go to IDLE next edge, dropping op, busy, error; halt wins over simultaneous load_start or byte accept, and the byte is not written.
REQ-028 user_write_memory SHALL never be 1 while op is 1.

Reset
REQ-029 On reset SHALL enter IDLE; user_address=0, in_data=0, user_write_memory=0, op=0, byte_ready=0, busy=0, error=0; index, sum, length, timeout counter cleared.
REQ-030 reset during DATA SHALL abort with no further write strobe; memory content already written is left as is.

Structure
REQ-031 State encoding and the ERR/RUN state constants SHALL live in the shared processor package.
REQ-032 The timeout counter SHALL be one sub-module, loader_watchdog (clear, enable, limit, expired).

Verification
REQ-033 load_start, stream 03,11,22,33,66 -> writes 11@00,22@01,33@02, one strobe each, then op=1, error=0.
REQ-034 START_ADDR=8'hFE, stream 03,01,02,03,06 -> writes at FE,FF,00, then op=1.
REQ-035 stream 02,05,05,0B (bad sum) -> two writes, then error=1, op stays 0; load_start recovers to LEN.
REQ-036 TIMEOUT=10, stream 02,AA then byte_valid=0 for 10 cycles -> ERR, single write only.
REQ-037 halt in the same cycle as the 2nd data byte accept -> no strobe for it, IDLE next cycle; halt in RUN -> op=0 next cycle.
REQ-038 reset asserted mid-DATA -> all outputs at reset values next cycle, no further strobes.
